// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings, funct codes and the mul/div FSM state type
// for the MIPS execute stage.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_DIV  = 4'b1011;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX, MD_DONE} md_state_e;

  // mult/multu/div/divu share the 0110xx funct prefix
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative magnitude datapath: shift/add multiply and restoring divide,
// one step per cycle, with sign fix-up into HI/LO.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic [1:0]       op_i,      // {divide, unsigned}
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             is_div_q, sgn_a_q, sgn_b_q;
  logic [WIDTH-1:0] acc_q, sh_q, opnd_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;

  logic             neg_a, neg_b, fits;
  logic [WIDTH-1:0] mag_a, mag_b, diff, quo, rem;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod;

  assign neg_a = !op_i[0] && src_a_i[WIDTH-1];
  assign neg_b = !op_i[0] && src_b_i[WIDTH-1];
  assign mag_a = neg_a ? -src_a_i : src_a_i;
  assign mag_b = neg_b ? -src_b_i : src_b_i;

  assign sum   = sh_q[0] ? {1'b0, acc_q} + {1'b0, opnd_q} : {1'b0, acc_q};
  assign trial = {acc_q, sh_q[WIDTH-1]};
  assign fits  = trial >= {1'b0, opnd_q};
  assign diff  = trial[WIDTH-1:0] - opnd_q;

  // A zero divisor accepts every trial, so the remainder path rebuilds the
  // dividend; only the quotient needs forcing to all ones.
  assign prod = (sgn_a_q ^ sgn_b_q) ? -{acc_q, sh_q} : {acc_q, sh_q};
  assign quo  = (opnd_q == '0) ? '1 : ((sgn_a_q ^ sgn_b_q) ? -sh_q : sh_q);
  assign rem  = sgn_a_q ? -acc_q : acc_q;

  assign last_o = cnt_q == CW'(WIDTH - 1);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_q <= 1'b0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (start_i) begin
        is_div_q <= op_i[1];
        sgn_a_q  <= neg_a;
        sgn_b_q  <= neg_b;
        acc_q    <= '0;
        cnt_q    <= '0;
        sh_q     <= op_i[1] ? mag_a : mag_b;
        opnd_q   <= op_i[1] ? mag_b : mag_a;
      end else if (step_i) begin
        cnt_q <= cnt_q + CW'(1);
        if (is_div_q) begin
          acc_q <= fits ? diff : trial[WIDTH-1:0];
          sh_q  <= {sh_q[WIDTH-2:0], fits};
        end else begin
          acc_q <= sum[WIDTH:1];
          sh_q  <= {sum[0], sh_q[WIDTH-1:1]};
        end
      end
      if (fix_i) begin
        hi_q <= is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_q <= is_div_q ? quo : prod[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv_exec_ctrl.sv
// Execute-stage control: ALU control decode plus the mul/div sequencer that
// stalls the pipeline while the iterative unit is busy.
module muldiv_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [3:0]       alu_ctrl,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e state_q;
  logic      md_busy_q, md_done_q;
  logic      md_req, start, last;

  always_comb begin
    alu_ctrl = ALU_AND;
    case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (funct)
          F_AND:           alu_ctrl = ALU_AND;
          F_OR:            alu_ctrl = ALU_OR;
          F_ADD:           alu_ctrl = ALU_ADD;
          F_SUB:           alu_ctrl = ALU_SUB;
          F_NOR:           alu_ctrl = ALU_NOR;
          F_SLT:           alu_ctrl = ALU_SLT;
          F_SLL:           alu_ctrl = ALU_SLL;
          F_SRL:           alu_ctrl = ALU_SRL;
          F_SRA:           alu_ctrl = ALU_SRA;
          F_XOR:           alu_ctrl = ALU_XOR;
          F_MULT, F_MULTU: alu_ctrl = ALU_MULT;
          F_DIV, F_DIVU:   alu_ctrl = ALU_DIV;
          default:         alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

  assign md_req = valid_in && (alu_op == 2'b10) && is_muldiv(funct);
  assign start  = (state_q == MD_IDLE) && md_req && !flush;
  // Low in DONE so the stalled instruction retires instead of restarting.
  assign stall  = !flush && (((state_q == MD_IDLE) && md_req) ||
                             (state_q == MD_RUN) || (state_q == MD_FIX));
  assign md_busy = md_busy_q;
  assign md_done = md_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: if (start) begin
          state_q   <= MD_RUN;
          md_busy_q <= 1'b1;
        end
        MD_RUN: if (flush) begin
          state_q   <= MD_IDLE;
          md_busy_q <= 1'b0;
        end else if (last) begin
          state_q <= MD_FIX;
        end
        MD_FIX: if (flush) begin
          state_q   <= MD_IDLE;
          md_busy_q <= 1'b0;
        end else begin
          state_q   <= MD_DONE;
          md_done_q <= 1'b1;
        end
        default: begin
          state_q   <= MD_IDLE;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .step_i  ((state_q == MD_RUN) && !flush),
    .fix_i   ((state_q == MD_FIX) && !flush),
    .op_i    (funct[1:0]),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .last_o  (last),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_muldiv_exec_ctrl.sv
// Self-checking bench for muldiv_exec_ctrl: decode table, directed and random
// mul/div against an arithmetic reference, flush/reset aborts, back-to-back.
module tb_muldiv_exec_ctrl;
  localparam int W = 32;

  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, flush = 1'b0;
  logic [1:0] alu_op = 2'b11;
  logic [5:0] funct = 6'b0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic [3:0] alu_ctrl;
  logic stall, md_busy, md_done;
  logic [W-1:0] hi, lo;

  int n_chk = 0, n_fail = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_exec_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op),
    .funct(funct), .src_a(src_a), .src_b(src_b), .flush(flush),
    .alu_ctrl(alu_ctrl), .stall(stall), .md_busy(md_busy),
    .md_done(md_done), .hi(hi), .lo(lo)
  );

  // Reference: plain integer arithmetic, returns {HI, LO}.
  function automatic logic [2*W-1:0] model(input logic [5:0] f,
                                           input logic [W-1:0] a, b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (f[1:0])
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == '0) return {a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
      end
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[W-1:0], uq[W-1:0]};
      end
    endcase
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, b,
                        input logic [2*W-1:0] expv, input string nm);
    int stalls;
    bit got;
    stalls = 0;
    got = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'b10; funct = f; src_a = a; src_b = b;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      if (md_done) got = 1'b1;
      else begin
        if (stall) stalls++;
        @(posedge clk); #1;
        src_a = $urandom; src_b = $urandom;
      end
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL %s timeout: md_done not seen", nm); end
    n_chk++;
    if (stalls != W + 2) begin n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, W + 2); end
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_in_done: got %b want 0", nm, stall); end
    n_chk++;
    if ({hi, lo} !== expv) begin n_fail++; $display("FAIL %s hi_lo: got %h_%h want %h", nm, hi, lo, expv); end
    exp_hi = expv[2*W-1:W];
    exp_lo = expv[W-1:0];
    @(posedge clk); #1;
    valid_in = 1'b0; alu_op = 2'b11;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({hi, lo} !== '0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
    n_chk++;
    if ({md_done, md_busy, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {md_done, md_busy, stall}); end
    n_chk++;
    if (alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_ctrl: got %b want 0000", alu_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    // {alu_op, funct, expected alu_ctrl}
    logic [11:0] tbl [20] = '{
      12'b00_100010_0010, 12'b01_101010_0110, 12'b11_100000_0000,
      12'b10_100100_0000, 12'b10_100101_0001, 12'b10_100000_0010,
      12'b10_100010_0110, 12'b10_100111_1100, 12'b10_101010_0111,
      12'b10_000000_1000, 12'b10_000010_1001, 12'b10_000011_1010,
      12'b10_100110_0100, 12'b10_011000_0101, 12'b10_011001_0101,
      12'b10_011010_1011, 12'b10_011011_1011, 12'b10_111111_0000,
      12'b10_000001_0000, 12'b10_001000_0000};
    logic [11:0] e;
    for (int i = 0; i < 20; i++) begin
      e = tbl[i];
      @(posedge clk); #1;
      alu_op = e[11:10]; funct = e[9:4];
      src_a = $urandom; src_b = $urandom;
      valid_in = !(e[11:10] == 2'b10 && e[9:6] == 4'b0110);
      @(negedge clk);
      n_chk++;
      if (alu_ctrl !== e[3:0]) begin n_fail++; $display("FAIL decode[%0d] alu_ctrl: got %b want %b", i, alu_ctrl, e[3:0]); end
      n_chk++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL decode[%0d] stall: got %b want 0", i, stall); end
    end
    @(posedge clk); #1;
    valid_in = 1'b0; alu_op = 2'b11;
    @(negedge clk);
    n_chk++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL decode_hilo_kept: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_directed();
    run_op(6'b011000, 32'hFFFFFFF9, 32'd3, 64'hFFFFFFFF_FFFFFFEB, "mult_m7x3");
    run_op(6'b011010, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, "div_100_m7");
    run_op(6'b011011, 32'hFFFFFFFF, 32'd2, 64'h00000001_7FFFFFFF, "divu_max_2");
    run_op(6'b011010, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, "div_5_0");
    run_op(6'b011010, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, "div_m5_0");
    run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf");
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      f = {4'b0110, 2'($urandom)};
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = '0;
      else if (i % 3 == 0) b = W'($urandom_range(1, 20)) ^ (b[0] ? '1 : '0);
      run_op(f, a, b, model(f, a, b), $sformatf("rand%0d_f%b", i, f));
    end
  endtask

  task automatic test_flush();
    int dones;
    run_op(6'b011011, 32'h56781234, 32'h00010000, 64'h00001234_00005678, "preload");
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'b011000; src_a = 32'd7; src_b = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({stall, md_busy} !== 2'b01) begin n_fail++; $display("FAIL flush_run stall_busy: got %b want 01", {stall, md_busy}); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy: got %b want 0", md_busy); end
    dones = 0;
    repeat (40) begin @(negedge clk); if (md_done) dones++; end
    n_chk++;
    if (dones != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    n_chk++;
    if ({hi, lo} !== 64'h00001234_00005678) begin n_fail++; $display("FAIL flush_hilo: got %h_%h want 1234_5678", hi, lo); end
    // flush in the same cycle as the start request
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'b011010; flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_start stall: got %b want 0", stall); end
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_start busy: got %b want 0", md_busy); end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'b011001; src_a = 32'd11; src_b = 32'd13;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    n_chk++;
    if ({hi, lo} !== '0) begin n_fail++; $display("FAIL rst_abort hilo: got %h_%h want 0", hi, lo); end
    n_chk++;
    if ({md_busy, stall} !== 2'b00) begin n_fail++; $display("FAIL rst_abort busy_stall: got %b want 00", {md_busy, stall}); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_back_to_back();
    bit got1, got2;
    int gap;
    got1 = 1'b0; got2 = 1'b0; gap = 0;
    @(posedge clk); #1;
    valid_in = 1'b1; alu_op = 2'b10; funct = 6'b011001; src_a = 32'd3; src_b = 32'd4;
    for (int c = 0; c < 80 && !got1; c++) begin
      @(negedge clk);
      if (md_done) got1 = 1'b1;
    end
    n_chk++;
    if (!got1 || {hi, lo} !== 64'd12) begin n_fail++; $display("FAIL b2b_first: done=%b got %h_%h want 0_c", got1, hi, lo); end
    @(posedge clk); #1;
    funct = 6'b011000; src_a = 32'd2; src_b = 32'd2;
    for (int c = 0; c < 80 && !got2; c++) begin
      @(negedge clk);
      gap++;
      if (md_done) got2 = 1'b1;
    end
    n_chk++;
    if (!got2 || gap != W + 3) begin n_fail++; $display("FAIL b2b_gap: done=%b got %0d want %0d", got2, gap, W + 3); end
    n_chk++;
    if ({hi, lo} !== 64'd4) begin n_fail++; $display("FAIL b2b_final: got %h_%h want 0_4", hi, lo); end
    @(posedge clk); #1;
    valid_in = 1'b0; alu_op = 2'b11;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_decode();
    test_random();
    test_flush();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
